// File: rtl/baggage_drop_sequencer.sv
// Control sequencer for one baggage-drop transaction: debounce, sample, verdict,
// drop handshake and fault handling. All outputs come straight from flops.
module baggage_drop_sequencer #(
  parameter int T_W            = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int SAMPLE_TIMEOUT = 1000,
  parameter int DROP_TIMEOUT   = 5000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bag_present,
  input  logic           sensor_valid,
  input  logic [T_W-1:0] t_act_in,
  input  logic [T_W-1:0] t_lim_in,
  input  logic           drop_done,
  input  logic           fault_clr,
  output logic           drop_en,
  output logic [T_W-1:0] t_act,
  output logic [T_W-1:0] t_lim,
  output logic           drop_req,
  output logic           busy,
  output logic           fault,
  output logic [2:0]     state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_DROP   = 3'd3,
    S_REJECT = 3'd4,
    S_DONE   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_TIMEOUT - 1);
  localparam logic [15:0] DROP_LAST   = 16'(DROP_TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [T_W-1:0] t_act_q, t_act_d, t_lim_q, t_lim_d;
  logic [T_W-1:0] t_act_o_q, t_act_o_d, t_lim_o_q, t_lim_o_d;
  logic           drop_en_q, drop_en_d, drop_req_q, drop_req_d;
  logic           busy_q, busy_d, fault_q, fault_d;

  // In REJECT the datapath must see act strictly greater than lim.
  function automatic logic [2*T_W-1:0] reject_view(input logic [T_W-1:0] a,
                                                   input logic [T_W-1:0] l);
    if (a > l)
      return {a, l};
    else if (a != '0)
      return {a, a - T_W'(1)};
    else
      return {T_W'(1), {T_W{1'b0}}};
  endfunction

  always_comb begin
    state_d = state_q;
    t_act_d = t_act_q;
    t_lim_d = t_lim_q;
    case (state_q)
      S_IDLE:   if (bag_present) state_d = S_SETTLE;
      S_SETTLE: begin
        if (!bag_present)              state_d = S_IDLE;
        else if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (!bag_present) begin
          state_d = S_IDLE;
        end else if (sensor_valid) begin
          t_act_d = t_act_in;
          t_lim_d = t_lim_in;
          state_d = (t_act_in < t_lim_in) ? S_DROP : S_REJECT;
        end else if (cnt_q == SAMPLE_LAST) begin
          state_d = S_FAULT;
        end
      end
      S_DROP: begin
        if (drop_done)               state_d = S_DONE;
        else if (cnt_q == DROP_LAST) state_d = S_FAULT;
      end
      S_REJECT, S_DONE: if (!bag_present) state_d = S_IDLE;
      S_FAULT:  if (fault_clr) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;

    // Outputs are computed from next-state values so they land on the same edge.
    drop_en_d  = (state_d == S_DROP) || (state_d == S_REJECT) || (state_d == S_DONE);
    drop_req_d = (state_d == S_DROP);
    busy_d     = (state_d != S_IDLE);
    fault_d    = (state_d == S_FAULT);
    if (state_d == S_REJECT)
      {t_act_o_d, t_lim_o_d} = reject_view(t_act_d, t_lim_d);
    else
      {t_act_o_d, t_lim_o_d} = {t_act_d, t_lim_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      t_act_q    <= '0;
      t_lim_q    <= '0;
      t_act_o_q  <= '0;
      t_lim_o_q  <= '0;
      drop_en_q  <= 1'b0;
      drop_req_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      t_act_q    <= t_act_d;
      t_lim_q    <= t_lim_d;
      t_act_o_q  <= t_act_o_d;
      t_lim_o_q  <= t_lim_o_d;
      drop_en_q  <= drop_en_d;
      drop_req_q <= drop_req_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  assign drop_en  = drop_en_q;
  assign drop_req = drop_req_q;
  assign busy     = busy_q;
  assign fault    = fault_q;
  assign t_act    = t_act_o_q;
  assign t_lim    = t_lim_o_q;
  assign state    = state_q;

endmodule
